alu32_arbiter: RTL
==================

# alu32_arbiter

Shares one `alu32` instance between two requesters with valid/ready handshakes and round-robin arbitration. Each requester submits operands plus a one-hot 6-bit function code and gets back a registered result (out/zero/overflow/error) in its own response slot, held until acknowledged. It sits between the instruction-sequencing logic and the ALU datapath, and is the only block that drives `alu32` op inputs.

## Interface
- CNT_W, 12, width of the accepted-operation counter `op_cnt`
- m_clock  in  1  clock; all state updates on rising edge
- p_reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- rN_valid  in  1  requester N (N=0,1) request valid
- rN_ready  out  1  request accepted this cycle when valid && ready
- rN_a, rN_b  in  32  operands
- rN_f  in  6  function, one-hot: 100000 add, 010000 sub, 001000 and, 000100 or, 000010 xor, 000001 nor
- rN_rvalid  out  1  response slot N full
- rN_rready  in  1  requester N consumes response
- rN_out  out  32  result
- rN_zero  out  1  alu32 zero flag
- rN_ov  out  1  alu32 overflow flag
- rN_err  out  1  rN_f was not one-hot
- op_cnt  out  CNT_W  number of accepted requests, wraps

## Operation
- Slot N state: EMPTY -> FULL on accept of N; FULL -> EMPTY on rN_rvalid && rN_rready with no new accept of N; FULL -> FULL (new data) when consume and accept of N occur in the same cycle.
- Eligible(N) = rN_valid && (slot EMPTY || rN_rready).
- At most one grant per cycle. One eligible: it wins. Both eligible: the requester not equal to `last` wins; `last` updates to the winner on every grant.
- rN_ready = grant to N (combinational from valid, slot state, rready, last). ready never asserted without valid.
- Granted requester's a, b drive alu32; the op input matching the single set bit of f is 1, all others 0. No grant: all op inputs 0, operands 0.
- Illegal f (zero or more than one bit set): alu32 ops all 0; slot loads out=0, zero=0, ov=0, err=1. Request is still accepted and counted.
- Legal f: slot loads alu32 out/zero/overflow, err=0.
- Slot outputs stay stable while FULL and not consumed, regardless of other requester's traffic.
- op_cnt increments by 1 per accept; 2^CNT_W-1 wraps to 0.

## Timing
- Reset (p_reset=0, asynchronous): rN_rvalid=0, rN_out=0, rN_zero=0, rN_ov=0, rN_err=0, op_cnt=0, last=1 (requester 0 wins first tie). rN_ready=0 while in reset. In-flight responses are discarded.
- Latency: request accepted at edge N -> rN_rvalid=1 with result in the cycle after edge N (1 cycle).
- Throughput: one accept per cycle total; one requester alone sustains one per cycle if it asserts rready in the cycle its response is valid.
- With both requesters saturating, grants alternate 0,1,0,1...
- Slot FULL with rready=0 blocks that requester only; the other keeps full throughput.
- Deassertion of p_reset is synchronized externally; the first grant can occur on the first edge after release.

## Structure
- Shared package `alu_pkg`: one-hot op constants OP_ADD..OP_NOR, op width (6), data width (32), and a one-hot legality function.
- One sub-module: `alu32` (existing), instantiated once. Arbitration and slots stay in this module; slot logic is written once and generated for N=0,1.

## Test plan
- Single op: r0 a=5, b=3, f=100000 -> r0_ready=1 same cycle; next cycle r0_rvalid=1, out=8, zero=0, ov=0, err=0; op_cnt=1.
- Overflow/zero: r1 a=0x7FFFFFFF, b=1, f=100000 -> out=0x80000000, ov=1; then a=7, b=7, f=010000 -> out=0, zero=1.
- Contention: both valid every cycle, both rready=1, after reset -> grants 0,1,0,1; r0 sees and(0xF0,0x3C)=0x30, r1 sees nor(0,0)=0xFFFFFFFF.
- Backpressure: r0 rready=0 with slot full, r0 valid -> r0_ready=0, r0 outputs frozen; r1 granted every cycle; raising r0 rready gives r0 grant that same cycle.
- Illegal op: f=000000 and f=110000 -> accepted, out=0, err=1, no alu32 op asserted; op_cnt increments; op_cnt wraps 4095->0.
- Reset mid-operation: assert p_reset low while r0_rvalid=1 -> r0_rvalid=0, outputs 0 immediately (no clock), op_cnt=0; after release, tie goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: one-hot function codes, datapath widths and a
// legality check for function codes.
package alu_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND = 6'b001000;
  localparam logic [OP_W-1:0] OP_OR  = 6'b000100;
  localparam logic [OP_W-1:0] OP_XOR = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOR = 6'b000001;

  function automatic logic is_onehot(input logic [OP_W-1:0] f);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < OP_W; i++) begin
      cnt = cnt + {2'b00, f[i]};
    end
    return (cnt == 3'd1);
  endfunction

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU with one strobe per operation; with no strobe
// asserted the result is 0.
import alu_pkg::*;

module alu32 (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_op_add,
  input  logic              i_op_sub,
  input  logic              i_op_and,
  input  logic              i_op_or,
  input  logic              i_op_xor,
  input  logic              i_op_nor,
  output logic [DATA_W-1:0] o_out,
  output logic              o_zero,
  output logic              o_overflow
);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  // Signed overflow exists only for add and sub.
  always_comb begin
    o_out      = {DATA_W{1'b0}};
    o_overflow = 1'b0;
    if (i_op_add) begin
      o_out      = w_sum;
      o_overflow = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
    end else if (i_op_sub) begin
      o_out      = w_diff;
      o_overflow = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);
    end else if (i_op_and) begin
      o_out = i_a & i_b;
    end else if (i_op_or) begin
      o_out = i_a | i_b;
    end else if (i_op_xor) begin
      o_out = i_a ^ i_b;
    end else if (i_op_nor) begin
      o_out = ~(i_a | i_b);
    end else begin
      o_out = {DATA_W{1'b0}};
    end
  end

  assign o_zero = (o_out == {DATA_W{1'b0}});

endmodule

// File: rtl/alu32_arbiter.sv
// Round-robin sharing of one alu32 between two valid/ready requesters, each
// with its own registered response slot held until acknowledged.
import alu_pkg::*;

module alu32_arbiter #(
  parameter int CNT_W = 12
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [OP_W-1:0]   r0_f,
  output logic              r0_rvalid,
  input  logic              r0_rready,
  output logic [DATA_W-1:0] r0_out,
  output logic              r0_zero,
  output logic              r0_ov,
  output logic              r0_err,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r1_f,
  output logic              r1_rvalid,
  input  logic              r1_rready,
  output logic [DATA_W-1:0] r1_out,
  output logic              r1_zero,
  output logic              r1_ov,
  output logic              r1_err,
  output logic [CNT_W-1:0]  op_cnt
);

  logic [1:0]        w_valid;
  logic [1:0]        w_rready;
  logic [1:0]        w_elig;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [OP_W-1:0]   w_op_f;
  logic              w_legal;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_alu_out;
  logic              w_alu_zero;
  logic              w_alu_ov;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;

  assign w_valid  = {r1_valid, r0_valid};
  assign w_rready = {r1_rready, r0_rready};

  // Tie goes to the requester that did not win last; nothing granted in reset.
  always_comb begin
    w_gnt = 2'b00;
    if (!p_reset) begin
      w_gnt = 2'b00;
    end else if (w_elig == 2'b11) begin
      w_gnt = r_last ? 2'b01 : 2'b10;
    end else begin
      w_gnt = w_elig;
    end
  end

  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1];

  always_comb begin
    w_op_a = {DATA_W{1'b0}};
    w_op_b = {DATA_W{1'b0}};
    w_op_f = {OP_W{1'b0}};
    if (w_any) begin
      w_op_a = w_sel ? r1_a : r0_a;
      w_op_b = w_sel ? r1_b : r0_b;
      w_op_f = w_sel ? r1_f : r0_f;
    end else begin
      w_op_a = {DATA_W{1'b0}};
      w_op_b = {DATA_W{1'b0}};
      w_op_f = {OP_W{1'b0}};
    end
  end

  assign w_legal = is_onehot(w_op_f);
  assign w_op    = (w_any && w_legal) ? w_op_f : {OP_W{1'b0}};

  alu32 u_alu (
    .i_a        (w_op_a),
    .i_b        (w_op_b),
    .i_op_add   (w_op[5]),
    .i_op_sub   (w_op[4]),
    .i_op_and   (w_op[3]),
    .i_op_or    (w_op[2]),
    .i_op_xor   (w_op[1]),
    .i_op_nor   (w_op[0]),
    .o_out      (w_alu_out),
    .o_zero     (w_alu_zero),
    .o_overflow (w_alu_ov)
  );

  for (genvar n = 0; n < 2; n++) begin : g_slot
    logic              r_full;
    logic [DATA_W-1:0] r_out;
    logic              r_zero;
    logic              r_ov;
    logic              r_err;

    assign w_elig[n] = w_valid[n] && (!r_full || w_rready[n]);

    // A new accept overrides a same-cycle consume; data is held otherwise.
    always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
        r_full <= 1'b0;
        r_out  <= {DATA_W{1'b0}};
        r_zero <= 1'b0;
        r_ov   <= 1'b0;
        r_err  <= 1'b0;
      end else if (w_gnt[n]) begin
        r_full <= 1'b1;
        r_out  <= w_legal ? w_alu_out : {DATA_W{1'b0}};
        r_zero <= w_legal && w_alu_zero;
        r_ov   <= w_legal && w_alu_ov;
        r_err  <= !w_legal;
      end else if (r_full && w_rready[n]) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_last <= 1'b1;
      r_cnt  <= {CNT_W{1'b0}};
    end else if (w_any) begin
      r_last <= w_sel;
      r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign r0_ready  = w_gnt[0];
  assign r1_ready  = w_gnt[1];
  assign r0_rvalid = g_slot[0].r_full;
  assign r0_out    = g_slot[0].r_out;
  assign r0_zero   = g_slot[0].r_zero;
  assign r0_ov     = g_slot[0].r_ov;
  assign r0_err    = g_slot[0].r_err;
  assign r1_rvalid = g_slot[1].r_full;
  assign r1_out    = g_slot[1].r_out;
  assign r1_zero   = g_slot[1].r_zero;
  assign r1_ov     = g_slot[1].r_ov;
  assign r1_err    = g_slot[1].r_err;
  assign op_cnt    = r_cnt;

endmodule
